// File: rtl/vga_timing_pkg.sv
// Shared constants and helpers for the raster timing generator and its per-axis counter.
// Two standard modes are provided: 640x480@60 and 800x600 (positive syncs).
package vga_timing_pkg;

  localparam int VGA640_H_ACTIVE = 640;
  localparam int VGA640_H_FP     = 16;
  localparam int VGA640_H_SYNC   = 96;
  localparam int VGA640_H_BP     = 48;
  localparam int VGA640_V_ACTIVE = 480;
  localparam int VGA640_V_FP     = 10;
  localparam int VGA640_V_SYNC   = 2;
  localparam int VGA640_V_BP     = 33;
  localparam bit VGA640_HS_POL   = 1'b0;
  localparam bit VGA640_VS_POL   = 1'b0;

  localparam int SVGA800_H_ACTIVE = 800;
  localparam int SVGA800_H_FP     = 40;
  localparam int SVGA800_H_SYNC   = 128;
  localparam int SVGA800_H_BP     = 88;
  localparam int SVGA800_V_ACTIVE = 600;
  localparam int SVGA800_V_FP     = 1;
  localparam int SVGA800_V_SYNC   = 4;
  localparam int SVGA800_V_BP     = 23;
  localparam bit SVGA800_HS_POL   = 1'b1;
  localparam bit SVGA800_VS_POL   = 1'b1;

  function automatic int vga_total(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

endpackage

// File: rtl/vga_axis_timing.sv
// One raster axis: a wrapping counter that resets to its last value, plus active/sync
// decode of the value it is about to take, so decodes line up with the count.
module vga_axis_timing
  import vga_timing_pkg::*;
#(
  parameter int ACTIVE = 640,
  parameter int FP     = 16,
  parameter int SYNC   = 96,
  parameter int BP     = 48,
  parameter bit POL    = 1'b0,
  parameter int WIDTH  = 12
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             adv_i,
  output logic [WIDTH-1:0] cnt_o,
  output logic [WIDTH-1:0] nxt_o,
  output logic             last_o,
  output logic             active_nxt_o,
  output logic             sync_o
);

  localparam int TOTAL   = vga_total(ACTIVE, FP, SYNC, BP);
  localparam int SYNC_LO = ACTIVE + FP;
  localparam int SYNC_HI = ACTIVE + FP + SYNC;

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             sync_q, sync_d;

  always_comb begin
    cnt_d = cnt_q;
    if (adv_i) begin
      cnt_d = last_o ? '0 : cnt_q + WIDTH'(1);
    end
    active_nxt_o = cnt_d < WIDTH'(ACTIVE);
    sync_d = ((cnt_d >= WIDTH'(SYNC_LO)) && (cnt_d < WIDTH'(SYNC_HI))) ? POL : ~POL;
  end

  assign last_o = (cnt_q == WIDTH'(TOTAL - 1));
  assign cnt_o  = cnt_q;
  assign nxt_o  = cnt_d;
  assign sync_o = sync_q;

  // The last count sits in the back porch, so ~POL is also its decoded sync level.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q  <= WIDTH'(TOTAL - 1);
      sync_q <= ~POL;
    end else begin
      cnt_q  <= cnt_d;
      sync_q <= sync_d;
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised raster timing generator with pixel clock-enable, programmable sync polarity,
// line/frame pulses, a frame counter and a look-ahead fetch coordinate.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE  = VGA640_H_ACTIVE,
  parameter int H_FP      = VGA640_H_FP,
  parameter int H_SYNC    = VGA640_H_SYNC,
  parameter int H_BP      = VGA640_H_BP,
  parameter int V_ACTIVE  = VGA640_V_ACTIVE,
  parameter int V_FP      = VGA640_V_FP,
  parameter int V_SYNC    = VGA640_V_SYNC,
  parameter int V_BP      = VGA640_V_BP,
  parameter bit HS_POL    = VGA640_HS_POL,
  parameter bit VS_POL    = VGA640_VS_POL,
  parameter int H_WIDTH   = 12,
  parameter int V_WIDTH   = 11,
  parameter int LOOKAHEAD = 2,
  parameter int FC_WIDTH  = 8
) (
  input  logic                CLK,
  input  logic                reset_n,
  input  logic                pix_ce,
  output logic [H_WIDTH-1:0]  hcounter,
  output logic [V_WIDTH-1:0]  vcounter,
  output logic                visible,
  output logic                oHS,
  output logic                oVS,
  output logic                line_start,
  output logic                frame_start,
  output logic [FC_WIDTH-1:0] frame_count,
  output logic [H_WIDTH-1:0]  fetch_x,
  output logic [V_WIDTH-1:0]  fetch_y,
  output logic                fetch_valid
);

  localparam int H_TOTAL = vga_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = vga_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam int FX_W    = H_WIDTH + 1;
  // Fetch position the reset state would decode to, so the first pixel edge continues smoothly.
  localparam int FX_RST  = (LOOKAHEAD == 0) ? H_TOTAL - 1 : LOOKAHEAD - 1;
  localparam int FY_RST  = (LOOKAHEAD == 0) ? V_TOTAL - 1 : 0;

  logic [H_WIDTH-1:0] h_nxt;
  logic [V_WIDTH-1:0] v_nxt;
  logic               h_last, v_last, h_act_nxt, v_act_nxt;
  logic               v_adv;

  assign v_adv = pix_ce & h_last;

  vga_axis_timing #(
    .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP), .POL(HS_POL), .WIDTH(H_WIDTH)
  ) u_h_axis (
    .clk_i        (CLK),
    .rst_ni       (reset_n),
    .adv_i        (pix_ce),
    .cnt_o        (hcounter),
    .nxt_o        (h_nxt),
    .last_o       (h_last),
    .active_nxt_o (h_act_nxt),
    .sync_o       (oHS)
  );

  vga_axis_timing #(
    .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP), .POL(VS_POL), .WIDTH(V_WIDTH)
  ) u_v_axis (
    .clk_i        (CLK),
    .rst_ni       (reset_n),
    .adv_i        (v_adv),
    .cnt_o        (vcounter),
    .nxt_o        (v_nxt),
    .last_o       (v_last),
    .active_nxt_o (v_act_nxt),
    .sync_o       (oVS)
  );

  logic [FX_W-1:0]     fx_sum;
  logic                fx_ovf;
  logic [H_WIDTH-1:0]  fetch_x_d;
  logic [V_WIDTH-1:0]  fetch_y_d, v_inc;
  logic                fetch_valid_d, line_start_d, frame_start_d;
  logic                visible_q, line_start_q, frame_start_q, fetch_valid_q;
  logic [FC_WIDTH-1:0] frame_count_q;
  logic [H_WIDTH-1:0]  fetch_x_q;
  logic [V_WIDTH-1:0]  fetch_y_q;

  always_comb begin
    fx_sum        = {1'b0, h_nxt} + FX_W'(LOOKAHEAD);
    fx_ovf        = fx_sum >= FX_W'(H_TOTAL);
    fetch_x_d     = fx_ovf ? H_WIDTH'(fx_sum - FX_W'(H_TOTAL)) : fx_sum[H_WIDTH-1:0];
    v_inc         = (v_nxt == V_WIDTH'(V_TOTAL - 1)) ? '0 : v_nxt + V_WIDTH'(1);
    fetch_y_d     = fx_ovf ? v_inc : v_nxt;
    fetch_valid_d = (fetch_x_d < H_WIDTH'(H_ACTIVE)) && (fetch_y_d < V_WIDTH'(V_ACTIVE));
    line_start_d  = pix_ce & h_last;
    frame_start_d = pix_ce & h_last & v_last;
  end

  // Pulses are refreshed every CLK so they never outlive one cycle; levels move only with pix_ce.
  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      visible_q     <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      frame_count_q <= '0;
      fetch_x_q     <= H_WIDTH'(FX_RST);
      fetch_y_q     <= V_WIDTH'(FY_RST);
      fetch_valid_q <= 1'b0;
    end else begin
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
      if (pix_ce) begin
        visible_q     <= h_act_nxt & v_act_nxt;
        fetch_x_q     <= fetch_x_d;
        fetch_y_q     <= fetch_y_d;
        fetch_valid_q <= fetch_valid_d;
        if (frame_start_d) begin
          frame_count_q <= frame_count_q + FC_WIDTH'(1);
        end
      end
    end
  end

  assign visible     = visible_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;
  assign frame_count = frame_count_q;
  assign fetch_x     = fetch_x_q;
  assign fetch_y     = fetch_y_q;
  assign fetch_valid = fetch_valid_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: 640x480 defaults, 800x600 positive-sync mode and a tiny 15x8 raster
// used for whole-frame properties, all checked against hand-computed values.
module tb_vga_timing_gen;

  logic clk      = 1'b0;
  logic reset_n  = 1'b0;
  logic pix_ce_a = 1'b0;
  logic one      = 1'b1;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  // DUT A: 640x480 defaults
  logic [11:0] a_h, a_fx;
  logic [10:0] a_v, a_fy;
  logic        a_vis, a_hs, a_vs, a_ls, a_fs, a_fv;
  logic [7:0]  a_fc;

  vga_timing_gen u_dut_a (
    .CLK(clk), .reset_n(reset_n), .pix_ce(pix_ce_a),
    .hcounter(a_h), .vcounter(a_v), .visible(a_vis), .oHS(a_hs), .oVS(a_vs),
    .line_start(a_ls), .frame_start(a_fs), .frame_count(a_fc),
    .fetch_x(a_fx), .fetch_y(a_fy), .fetch_valid(a_fv)
  );

  // DUT B: 800x600 positive syncs
  logic [10:0] b_h, b_fx;
  logic [9:0]  b_v, b_fy;
  logic        b_vis, b_hs, b_vs, b_ls, b_fs, b_fv;
  logic [7:0]  b_fc;

  vga_timing_gen #(
    .H_ACTIVE(800), .H_FP(40), .H_SYNC(128), .H_BP(88),
    .V_ACTIVE(600), .V_FP(1), .V_SYNC(4), .V_BP(23),
    .HS_POL(1'b1), .VS_POL(1'b1), .H_WIDTH(11), .V_WIDTH(10), .LOOKAHEAD(2), .FC_WIDTH(8)
  ) u_dut_b (
    .CLK(clk), .reset_n(reset_n), .pix_ce(one),
    .hcounter(b_h), .vcounter(b_v), .visible(b_vis), .oHS(b_hs), .oVS(b_vs),
    .line_start(b_ls), .frame_start(b_fs), .frame_count(b_fc),
    .fetch_x(b_fx), .fetch_y(b_fy), .fetch_valid(b_fv)
  );

  // DUT C: tiny 15x8 raster, 2-bit frame counter
  logic [3:0] c_h, c_fx;
  logic [2:0] c_v, c_fy;
  logic       c_vis, c_hs, c_vs, c_ls, c_fs, c_fv;
  logic [1:0] c_fc;

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HS_POL(1'b0), .VS_POL(1'b0), .H_WIDTH(4), .V_WIDTH(3), .LOOKAHEAD(2), .FC_WIDTH(2)
  ) u_dut_c (
    .CLK(clk), .reset_n(reset_n), .pix_ce(one),
    .hcounter(c_h), .vcounter(c_v), .visible(c_vis), .oHS(c_hs), .oVS(c_vs),
    .line_start(c_ls), .frame_start(c_fs), .frame_count(c_fc),
    .fetch_x(c_fx), .fetch_y(c_fy), .fetch_valid(c_fv)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic step_n(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic chk_a_reset(input string tag);
    chk({tag, "_h"},   a_h, 799);
    chk({tag, "_v"},   a_v, 524);
    chk({tag, "_vis"}, a_vis, 0);
    chk({tag, "_hs"},  a_hs, 1);
    chk({tag, "_vs"},  a_vs, 1);
    chk({tag, "_ls"},  a_ls, 0);
    chk({tag, "_fs"},  a_fs, 0);
    chk({tag, "_fc"},  a_fc, 0);
    chk({tag, "_fx"},  a_fx, 1);
    chk({tag, "_fy"},  a_fy, 0);
    chk({tag, "_fv"},  a_fv, 0);
  endtask

  int hs_cnt, hs_first, hs_last, vis_cnt;
  int bh_cnt, bh_first, bh_last;
  int c_vis_cnt, c_vs_cnt, c_hs_cnt, c_fs_cnt, c_vs_first;

  initial begin
    // ---- reset state ----
    step_n(2);
    chk_a_reset("rst");
    chk("rst_b_hs", b_hs, 0);
    chk("rst_b_vs", b_vs, 0);
    chk("rst_c_h", c_h, 14);
    chk("rst_c_fx", c_fx, 1);

    // ---- first pixel edge enters frame 1 ----
    reset_n  = 1'b1;
    pix_ce_a = 1'b1;
    step();
    chk("first_h", a_h, 0);
    chk("first_v", a_v, 0);
    chk("first_vis", a_vis, 1);
    chk("first_fs", a_fs, 1);
    chk("first_ls", a_ls, 1);
    chk("first_fc", a_fc, 1);
    chk("first_fx", a_fx, 2);
    chk("first_fv", a_fv, 1);

    // ---- one full line of A: hsync window, visible count, fetch wrap to next line ----
    hs_cnt = 0; hs_first = -1; hs_last = -1; vis_cnt = 0;
    for (int i = 0; i < 800; i++) begin
      if (i > 0) step();
      if (!a_hs) begin
        hs_cnt++;
        if (hs_first < 0) hs_first = int'(a_h);
        hs_last = int'(a_h);
      end
      if (a_vis) vis_cnt++;
      if (i == 798) begin
        chk("line0_fx_wrap", a_fx, 0);
        chk("line0_fy_wrap", a_fy, 1);
        chk("line0_fv_wrap", a_fv, 1);
      end
    end
    chk("hs_low_count", hs_cnt, 96);
    chk("hs_low_first", hs_first, 656);
    chk("hs_low_last", hs_last, 751);
    chk("vis_per_line", vis_cnt, 640);
    chk("end_line_h", a_h, 799);
    step();
    chk("wrap_h", a_h, 0);
    chk("wrap_v", a_v, 1);
    chk("wrap_ls", a_ls, 1);
    chk("wrap_fs", a_fs, 0);
    step();
    chk("ls_one_clk", a_ls, 0);

    // ---- fetch boundary at the right edge of the visible area ----
    step_n(7836);
    chk("nav_h637", a_h, 637);
    chk("nav_v10", a_v, 10);
    chk("h637_fx", a_fx, 639);
    chk("h637_fy", a_fy, 10);
    chk("h637_fv", a_fv, 1);
    step();
    chk("h638_fx", a_fx, 640);
    chk("h638_fv", a_fv, 0);

    // ---- pix_ce 1,0,0,1 across a line boundary ----
    step_n(161);
    chk("ce_pre_h", a_h, 799);
    step();
    chk("ce1_h", a_h, 0);
    chk("ce1_v", a_v, 11);
    chk("ce1_ls", a_ls, 1);
    pix_ce_a = 1'b0;
    step();
    chk("ce0a_h", a_h, 0);
    chk("ce0a_ls", a_ls, 0);
    chk("ce0a_vis", a_vis, 1);
    chk("ce0a_fx", a_fx, 2);
    step();
    chk("ce0b_h", a_h, 0);
    chk("ce0b_ls", a_ls, 0);
    pix_ce_a = 1'b1;
    step();
    chk("ce1b_h", a_h, 1);
    chk("ce1b_ls", a_ls, 0);

    // ---- asynchronous reset mid-frame ----
    step_n(299);
    chk("mid_h", a_h, 300);
    reset_n = 1'b0;
    #1;
    chk_a_reset("async");
    step_n(2);
    reset_n = 1'b1;
    step();
    chk("rel_h", a_h, 0);
    chk("rel_v", a_v, 0);
    chk("rel_fs", a_fs, 1);
    chk("rel_fc", a_fc, 1);

    // ---- 800x600 line on B, whole frames on C ----
    bh_cnt = 0; bh_first = -1; bh_last = -1;
    c_vis_cnt = 0; c_vs_cnt = 0; c_hs_cnt = 0; c_fs_cnt = 0; c_vs_first = -1;
    for (int i = 0; i < 1056; i++) begin
      if (i > 0) step();
      if (b_hs) begin
        bh_cnt++;
        if (bh_first < 0) bh_first = int'(b_h);
        bh_last = int'(b_h);
      end
      if (i == 1054) begin
        chk("b_fx_wrap", b_fx, 0);
        chk("b_fy_wrap", b_fy, 1);
        chk("b_fv_wrap", b_fv, 1);
      end
      if (i < 120) begin
        if (c_vis) c_vis_cnt++;
        if (!c_hs) c_hs_cnt++;
        if (c_fs) c_fs_cnt++;
        if (!c_vs) begin
          c_vs_cnt++;
          if (c_vs_first < 0) c_vs_first = int'(c_v);
        end
      end
      if (i == 117) begin
        chk("c_h12v7_fx", c_fx, 14);
        chk("c_h12v7_fy", c_fy, 7);
        chk("c_h12v7_fv", c_fv, 0);
      end
      if (i == 118) begin
        chk("c_frame_fx", c_fx, 0);
        chk("c_frame_fy", c_fy, 0);
        chk("c_frame_fv", c_fv, 1);
      end
      if (i == 120) begin
        chk("c_f2_fs", c_fs, 1);
        chk("c_f2_fc", c_fc, 2);
      end
      if (i == 360) begin
        chk("c_fc_wrap_fs", c_fs, 1);
        chk("c_fc_wrap", c_fc, 0);
      end
    end
    chk("b_hs_count", bh_cnt, 128);
    chk("b_hs_first", bh_first, 840);
    chk("b_hs_last", bh_last, 967);
    chk("b_last_h", b_h, 1055);
    step();
    chk("b_wrap_h", b_h, 0);
    chk("b_wrap_v", b_v, 1);
    chk("c_vis_frame", c_vis_cnt, 32);
    chk("c_hs_frame", c_hs_cnt, 24);
    chk("c_vs_frame", c_vs_cnt, 30);
    chk("c_vs_first", c_vs_first, 5);
    chk("c_fs_frame", c_fs_cnt, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
